// File: rtl/pc_seq.sv
// Program counter sequencer: IDLE/RUN/HALT control with call/return/jump/branch.
// Define CALL_GUARD_EN to add a one-entry call-depth check that drives a sticky err.
module pc_seq #(
    parameter int                    CNTR_WIDTH   = 8,
    parameter logic [CNTR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  hlt_f,
    input  logic                  ret_f,
    input  logic                  cal_f,
    input  logic                  jmp_f,
    input  logic                  brz_f,
    input  logic                  zero,
    input  logic [CNTR_WIDTH-1:0] target,
    input  logic [CNTR_WIDTH-1:0] ret_addr,
    output logic [CNTR_WIDTH-1:0] counter,
    output logic [CNTR_WIDTH-1:0] link_addr,
    output logic                  cal_we,
    output logic                  running,
    output logic                  halted,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNTR_WIDTH-1:0]   counter_nxt;
    logic                    run_go;
    logic                    ret_take;
    logic                    cal_take;

    assign link_addr = counter + CNTR_WIDTH'(1);

    // Accepted actions, resolved by priority hlt > ret > cal.
    assign run_go   = (state == S_RUN) && !stall;
    assign ret_take = run_go && !hlt_f && ret_f;
    assign cal_take = run_go && !hlt_f && !ret_f && cal_f;
    assign cal_we   = cal_take;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        unique case (state)
            S_IDLE: begin
                counter_nxt = RESET_VECTOR;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (run_go) begin
                    if (hlt_f)                    state_nxt   = S_HALT;
                    else if (ret_f)               counter_nxt = ret_addr;
                    else if (cal_f)               counter_nxt = target;
                    else if (jmp_f)               counter_nxt = target;
                    else if (brz_f && zero)       counter_nxt = target;
                    else                          counter_nxt = link_addr;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt   = S_RUN;
                    counter_nxt = RESET_VECTOR;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                counter_nxt = RESET_VECTOR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            counter <= RESET_VECTOR;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            running <= (state_nxt == S_RUN);
            halted  <= (state_nxt == S_HALT);
        end
    end

`ifdef CALL_GUARD_EN
    logic depth_q;
    logic depth_nxt;
    logic err_q;
    logic err_nxt;

    // The call register holds one entry: a second call overwrites it, and a
    // return with nothing stored pops garbage. Both are flagged, not blocked.
    always_comb begin
        depth_nxt = depth_q;
        err_nxt   = err_q;
        if (start && (state != S_RUN)) begin
            depth_nxt = 1'b0;
            err_nxt   = 1'b0;
        end else if (cal_take) begin
            if (depth_q) err_nxt = 1'b1;
            depth_nxt = 1'b1;
        end else if (ret_take) begin
            if (!depth_q) err_nxt = 1'b1;
            depth_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_nxt;
            err_q   <= err_nxt;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus a randomized run
// against a behavioural model. Honours CALL_GUARD_EN for err expectations.
module tb_pc_seq;

    localparam int W = 8;
`ifdef CALL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic         hlt_f = 1'b0;
    logic         ret_f = 1'b0;
    logic         cal_f = 1'b0;
    logic         jmp_f = 1'b0;
    logic         brz_f = 1'b0;
    logic         zero = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] ret_addr = '0;
    logic [W-1:0] counter;
    logic [W-1:0] link_addr;
    logic         cal_we;
    logic         running;
    logic         halted;
    logic         err;

    int total = 0;
    int bad   = 0;

    pc_seq #(.CNTR_WIDTH(W), .RESET_VECTOR(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .hlt_f     (hlt_f),
        .ret_f     (ret_f),
        .cal_f     (cal_f),
        .jmp_f     (jmp_f),
        .brz_f     (brz_f),
        .zero      (zero),
        .target    (target),
        .ret_addr  (ret_addr),
        .counter   (counter),
        .link_addr (link_addr),
        .cal_we    (cal_we),
        .running   (running),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start = 0; stall = 0; hlt_f = 0; ret_f = 0; cal_f = 0;
        jmp_f = 0; brz_f = 0; zero = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic go_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic goto_addr(input logic [W-1:0] a);
        jmp_f = 1'b1;
        target = a;
        tick();
        jmp_f = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        #3;
        total++; if (counter !== 8'h00) begin bad++; $display("FAIL reset_counter: got %h exp 00", counter); end
        total++; if ({running, halted, err, cal_we} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b exp 0000", {running, halted, err, cal_we}); end
        tick();
        rst_n = 1'b1;
        // Flags without start must leave the block in IDLE.
        for (int i = 0; i < 4; i++) begin
            {hlt_f, ret_f, cal_f, jmp_f, brz_f, zero} = 6'($urandom);
            target = 8'($urandom);
            ret_addr = 8'($urandom);
            tick();
            total++; if (counter !== 8'h00 || running !== 1'b0 || cal_we !== 1'b0) begin bad++; $display("FAIL idle_hold: counter=%h running=%b cal_we=%b exp 00/0/0", counter, running, cal_we); end
        end
        clear_in();
    endtask

    task automatic test_count();
        do_reset();
        go_run();
        total++; if (counter !== 8'h00 || running !== 1'b1) begin bad++; $display("FAIL start: counter=%h running=%b exp 00/1", counter, running); end
        for (int i = 1; i <= 4; i++) begin
            start = (i == 2);  // start while running must be ignored
            tick();
            total++; if (counter !== 8'(i)) begin bad++; $display("FAIL count_%0d: got %h exp %h", i, counter, 8'(i)); end
        end
        start = 1'b0;
    endtask

    task automatic test_call_ret();
        goto_addr(8'h10);
        total++; if (counter !== 8'h10) begin bad++; $display("FAIL goto_10: got %h exp 10", counter); end
        cal_f = 1'b1; target = 8'h40;
        #1;
        total++; if (cal_we !== 1'b1) begin bad++; $display("FAIL call_we: got %b exp 1", cal_we); end
        total++; if (link_addr !== 8'h11) begin bad++; $display("FAIL call_link: got %h exp 11", link_addr); end
        tick();
        cal_f = 1'b0;
        total++; if (counter !== 8'h40) begin bad++; $display("FAIL call_dest: got %h exp 40", counter); end
        ret_f = 1'b1; ret_addr = 8'h11;
        #1;
        total++; if (cal_we !== 1'b0) begin bad++; $display("FAIL ret_we: got %b exp 0", cal_we); end
        tick();
        ret_f = 1'b0;
        total++; if (counter !== 8'h11) begin bad++; $display("FAIL ret_dest: got %h exp 11", counter); end
    endtask

    task automatic test_priority();
        goto_addr(8'h20);
        cal_f = 1; ret_f = 1; jmp_f = 1; ret_addr = 8'h05; target = 8'h77;
        #1;
        total++; if (cal_we !== 1'b0) begin bad++; $display("FAIL prio_we: got %b exp 0", cal_we); end
        tick();
        clear_in();
        total++; if (counter !== 8'h05) begin bad++; $display("FAIL prio_ret: got %h exp 05", counter); end
        stall = 1; jmp_f = 1; cal_f = 1; target = 8'h99;
        #1;
        total++; if (cal_we !== 1'b0) begin bad++; $display("FAIL stall_we: got %b exp 0", cal_we); end
        tick();
        total++; if (counter !== 8'h05) begin bad++; $display("FAIL stall_hold: got %h exp 05", counter); end
        clear_in();
    endtask

    task automatic test_wrap_branch();
        goto_addr(8'hFF);
        total++; if (link_addr !== 8'h00) begin bad++; $display("FAIL link_wrap: got %h exp 00", link_addr); end
        tick();
        total++; if (counter !== 8'h00) begin bad++; $display("FAIL inc_wrap: got %h exp 00", counter); end
        brz_f = 1; zero = 0; target = 8'h80;
        tick();
        total++; if (counter !== 8'h01) begin bad++; $display("FAIL brz_nt: got %h exp 01", counter); end
        zero = 1;
        tick();
        total++; if (counter !== 8'h80) begin bad++; $display("FAIL brz_t: got %h exp 80", counter); end
        clear_in();
    endtask

    task automatic test_halt();
        goto_addr(8'h33);
        hlt_f = 1'b1;
        tick();
        total++; if (halted !== 1'b1 || running !== 1'b0 || counter !== 8'h33) begin bad++; $display("FAIL halt: halted=%b running=%b counter=%h exp 1/0/33", halted, running, counter); end
        for (int i = 0; i < 5; i++) begin
            {hlt_f, ret_f, cal_f, jmp_f, brz_f, zero, stall} = 7'($urandom);
            target = 8'($urandom);
            ret_addr = 8'($urandom);
            #1;
            total++; if (cal_we !== 1'b0) begin bad++; $display("FAIL halt_we: got %b exp 0", cal_we); end
            tick();
            total++; if (counter !== 8'h33 || halted !== 1'b1) begin bad++; $display("FAIL halt_hold: counter=%h halted=%b exp 33/1", counter, halted); end
        end
        clear_in();
        go_run();
        total++; if (counter !== 8'h00 || running !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL restart: counter=%h running=%b halted=%b exp 00/1/0", counter, running, halted); end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        total++; if (counter !== 8'h02) begin bad++; $display("FAIL pre_reset: got %h exp 02", counter); end
        stall = 1; jmp_f = 1; target = 8'h55;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (counter !== 8'h00 || running !== 1'b0) begin bad++; $display("FAIL async_reset: counter=%h running=%b exp 00/0", counter, running); end
        tick();
        rst_n = 1'b1;
        stall = 0;
        tick();
        total++; if (counter !== 8'h00 || running !== 1'b0) begin bad++; $display("FAIL release: counter=%h running=%b exp 00/0", counter, running); end
        clear_in();
    endtask

    task automatic test_err();
        do_reset();
        go_run();
        cal_f = 1; target = 8'h10;
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_one_call: got %b exp 0", err); end
        tick();
        cal_f = 0;
        total++; if (err !== GUARD) begin bad++; $display("FAIL err_two_calls: got %b exp %b", err, GUARD); end
        hlt_f = 1;
        tick();
        hlt_f = 0;
        go_run();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b exp 0", err); end
        do_reset();
        go_run();
        ret_f = 1; ret_addr = 8'h08;
        tick();
        ret_f = 0;
        total++; if (err !== GUARD || counter !== 8'h08) begin bad++; $display("FAIL err_bare_ret: err=%b counter=%h exp %b/08", err, counter, GUARD); end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=halt; depth counts stored calls.
    int           m_mode;
    int           m_depth;
    logic [W-1:0] m_pc;
    logic         m_err;

    task automatic test_random();
        logic exp_we;
        do_reset();
        m_mode = 0; m_depth = 0; m_pc = 8'h00; m_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 99) < 8);
            stall = ($urandom_range(0, 99) < 20);
            hlt_f = ($urandom_range(0, 99) < 3);
            ret_f = ($urandom_range(0, 99) < 20);
            cal_f = ($urandom_range(0, 99) < 25);
            jmp_f = ($urandom_range(0, 99) < 20);
            brz_f = ($urandom_range(0, 99) < 30);
            zero = 1'($urandom);
            target = 8'($urandom);
            ret_addr = 8'($urandom);
            #1;
            exp_we = (m_mode == 1) && !stall && cal_f && !hlt_f && !ret_f;
            total++; if (cal_we !== exp_we || link_addr !== 8'((int'(m_pc) + 1) % 256)) begin bad++; $display("FAIL rnd_comb %0d: cal_we=%b link=%h exp %b/%h", n, cal_we, link_addr, exp_we, 8'((int'(m_pc) + 1) % 256)); end
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_depth = 0; end
            end else if (m_mode == 2) begin
                if (start) begin m_mode = 1; m_pc = 8'h00; m_depth = 0; m_err = 1'b0; end
            end else if (!stall) begin
                if (hlt_f) m_mode = 2;
                else if (ret_f) begin
                    if (GUARD && m_depth == 0) m_err = 1'b1;
                    m_depth = 0;
                    m_pc = ret_addr;
                end else if (cal_f) begin
                    if (GUARD && m_depth == 1) m_err = 1'b1;
                    m_depth = 1;
                    m_pc = target;
                end else if (jmp_f || (brz_f && zero)) m_pc = target;
                else m_pc = 8'((int'(m_pc) + 1) % 256);
            end
            tick();
            total++; if (counter !== m_pc || running !== (m_mode == 1) || halted !== (m_mode == 2) || err !== m_err) begin
                bad++;
                $display("FAIL rnd_state %0d: counter=%h run=%b halt=%b err=%b exp %h/%b/%b/%b", n, counter, running, halted, err, m_pc, m_mode == 1, m_mode == 2, m_err);
            end
        end
        clear_in();
    endtask

    initial begin
        #1;
        test_reset();
        test_count();
        test_call_ret();
        test_priority();
        test_wrap_branch();
        test_halt();
        test_async_reset();
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL provide parameter CNTR_WIDTH, default 8: width of program counter, jump target and return address.
REQ-002 SHALL provide parameter RESET_VECTOR, default 0: counter value loaded at reset and on start.
REQ-003 SHALL provide ports (name direction width meaning):
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE/HALT, begin fetch at RESET_VECTOR.
- stall  in  1  freeze counter and ignore decode flags this cycle.
- hlt_f  in  1  decoded halt.
- ret_f  in  1  decoded return.
- cal_f  in  1  decoded call.
- jmp_f  in  1  decoded unconditional jump.
- brz_f  in  1  decoded branch-if-zero.
- zero  in  1  ALU zero flag.
- target  in  CNTR_WIDTH  jump/call/branch destination.
- ret_addr  in  CNTR_WIDTH  return address from the call register.
- counter  out  CNTR_WIDTH  current program counter.
- link_addr  out  CNTR_WIDTH  counter+1 mod 2^CNTR_WIDTH, fed to call register.
- cal_we  out  1  call register write strobe.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- err  out  1  sticky call-nesting error (see Configuration).

Function
REQ-004 SHALL implement FSM states IDLE, RUN, HALT; counter, running, halted, err registered.
REQ-005 IDLE: counter holds RESET_VECTOR; start=1 -> RUN next edge; decode flags ignored.
REQ-006 RUN, stall=1: counter holds, state holds, cal_we=0, all flags ignored.
REQ-007 RUN, stall=0: exactly one action per cycle by priority hlt_f > ret_f > cal_f > jmp_f > (brz_f & zero) > increment.
REQ-008 hlt_f: counter holds, state -> HALT next edge.
REQ-009 ret_f: counter <= ret_addr next edge.
REQ-010 cal_f (accepted): counter <= target next edge; cal_we=1 combinationally in the same cycle.
REQ-011 cal_we SHALL be 1 only when state=RUN, stall=0, cal_f=1, hlt_f=0, ret_f=0; 0 otherwise, including reset.
REQ-012 jmp_f or (brz_f & zero): counter <= target; brz_f with zero=0 increments.
REQ-013 increment SHALL wrap: counter = 2^CNTR_WIDTH-1 -> 0; link_addr wraps identically.
REQ-014 link_addr SHALL be combinational counter+1, valid every cycle.
REQ-015 HALT: counter holds; only start (-> RUN, counter <= RESET_VECTOR, err cleared) or reset exits.
REQ-016 start in RUN SHALL be ignored.
REQ-017 Counter update latency SHALL be one clock edge after the accepting cycle.

Reset
REQ-018 rst_n=0 SHALL immediately force state=IDLE, counter=RESET_VECTOR, running=0, halted=0, err=0, cal_we=0, independent of clk.
REQ-019 Reset asserted mid-operation (any state, stalled or not) SHALL abandon the in-flight action; no counter update on the release edge.
REQ-020 After rst_n release, block SHALL stay in IDLE until start=1.

Configuration
REQ-021 Macro CALL_GUARD_EN SHALL compile in a 1-bit call-depth flag (call register holds one entry).
REQ-022 With CALL_GUARD_EN: accepted call sets flag; accepted ret clears it; call with flag set or ret with flag clear sets err (sticky); the action itself is still performed.
REQ-023 Without CALL_GUARD_EN: no flag logic, err tied 0.

Verification
REQ-024 Reset, start, 4 idle cycles, CNTR_WIDTH=8, RESET_VECTOR=0 -> counter 0,1,2,3,4; running=1.
REQ-025 At counter=0x10 cal_f=1, target=0x40 -> cal_we=1 that cycle, link_addr=0x11, next counter=0x40; ret_f with ret_addr=0x11 -> counter=0x11.
REQ-026 cal_f+ret_f+jmp_f together at counter=0x20, ret_addr=0x05 -> counter=0x05, cal_we=0; then stall=1 with jmp_f -> counter stays 0x05.
REQ-027 counter=0xFF, no flags -> counter=0x00, link_addr at 0xFF = 0x00; brz_f with zero=0 -> increment, zero=1, target=0x80 -> 0x80.
REQ-028 hlt_f at 0x33 -> halted=1, counter stays 0x33 for 5 cycles; start -> counter=0x00, RUN; rst_n low mid-RUN -> counter=0 asynchronously.
REQ-029 CALL_GUARD_EN defined: two calls without ret -> err=1 after second; ret without call after reset -> err=1; undefined -> err stays 0.
